fetch_queue_unit: RTL

- Instruction-fetch front end; replaces the free-running PC/+4 path and sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory. Memory may answer with variable latency, in order.
- Buffers returned instructions with their PCs in a small queue and hands them to IF/ID over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from later stages, which flushes all younger fetch state.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_queue_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'd100;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC, credit-limited memory requests, redirect drop and output queue.
// Optional FETCH_PERF_EN adds saturating stall/drop performance counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_drop_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] pc_fifo [DEPTH];
  logic [PTR_W-1:0]  pc_wr;
  logic [PTR_W-1:0]  pc_rd;
  logic              issue;
  logic              push;
  logic              pop;
  logic              discard;
  logic              has_head;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  // Credits: queued entries plus in-flight requests never exceed DEPTH.
  assign inflight  = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = !rst && !redirect_valid && (inflight < (CNT_W + 1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  assign push      = imem_rvalid && !redirect_valid && (drop == '0);
  assign discard   = imem_rvalid && (redirect_valid || (drop != '0));
  assign has_head  = (count != '0);
  assign out_valid = has_head && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_instr = has_head ? head.instr : '0;
  assign out_pc    = has_head ? head.pc : '0;

  assign push_entry = '{instr: imem_rdata, pc: pc_fifo[pc_rd]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pc_wr       <= '0;
      pc_rd       <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);
      if (redirect_valid) begin
        // Every request still in flight before the redirect is stale.
        fetch_pc <= redirect_pc;
        drop     <= outstanding - CNT_W'(imem_rvalid);
        pc_wr    <= '0;
        pc_rd    <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + PC_STEP;
          pc_wr    <= pc_wr + PTR_W'(1);
        end
        if (imem_rvalid && (drop != '0)) drop <= drop - CNT_W'(1);
        if (push) pc_rd <= pc_rd + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_fifo[pc_wr] <= fetch_pc;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (discard && (perf_drop_cnt != '1)) perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif
endmodule
